// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
//
// Round-robin arbiter across four requesters, followed by a registered
// data mux. A grantee keeps the grant for at most HOLD consecutive cycles,
// or less if it drops its request. When the grant is released, the next
// requester is granted on the same edge, so no idle cycle is inserted
// between grants. The data path (out/valid) lags gnt/sel by one cycle.
//
// Parameters
//   WIDTH : data width of a, b, c, d and out (default 4)
//   HOLD  : maximum consecutive grant cycles per requester, 1..15 (default 2)
//
// Ports
//   clk   : in  : clock; all state updates on the rising edge
//   rst   : in  : asynchronous active-high reset
//   req   : in  : request bits [3:0] = {d, c, b, a}
//   a..d  : in  : requester data 0..3
//   lock  : in  : hold the current grant (present only with MUX_ARB_LOCK_EN)
//   sel   : out : registered index of the current grantee
//   gnt   : out : registered grant, one-hot or zero
//   out   : out : registered data selected by sel
//   valid : out : out holds granted data
//
// Build option
//   MUX_ARB_LOCK_EN : when defined, adds the lock input. While lock=1 and
//                     the grantee still requests, the hold-count release is
//                     suppressed. Once lock falls, the grantee gets HOLD more
//                     cycles.
// ---------------------------------------------------------------------------
module mux_arbiter #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
`ifdef MUX_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] gnt_n;
    logic [1:0] sel_n;

    logic [1:0] win;
    logic       found;
    logic [1:0] idx;
    logic       lock_hold;
    logic       grant_new;
    logic [WIDTH-1:0] mux_data;

    // Round-robin search. It starts one past the last grantee, so the
    // current grantee is checked last and wins only if nobody else requests.
    always_comb begin
        // NOTE: every variable gets a default before any branch. This keeps
        // the combinational block free of inferred latches.
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef MUX_ARB_LOCK_EN
        lock_hold = lock & req[sel];
`else
        lock_hold = 1'b0;
`endif
    end

    // Next-state and next-grant logic.
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        sel_n     = sel;
        ptr_n     = ptr;
        cnt_n     = cnt;
        grant_new = 1'b0;

        case (state)
            IDLE: begin
                if (|req) grant_new = 1'b1;
                else      gnt_n     = 4'b0000;
            end
            GRANT: begin
                if (lock_hold) begin
                    // Keep the counter primed, so that the grantee gets a
                    // full HOLD cycles after lock falls.
                    cnt_n = HOLD_M1;
                end else if (cnt == 4'd0 || !req[sel]) begin
                    if (|req) begin
                        grant_new = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase

        if (grant_new) begin
            state_n = GRANT;
            gnt_n   = 4'b0001 << win;
            sel_n   = win;
            ptr_n   = win;
            cnt_n   = HOLD_M1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, whatever the order of
    // the processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            cnt   <= 4'd0;
            ptr   <= 2'd3;  // requester 0 is searched first after reset
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        case (sel)
            2'd0:    mux_data = a;
            2'd1:    mux_data = b;
            2'd2:    mux_data = c;
            default: mux_data = d;
        endcase
    end

    // The data stage follows gnt/sel one cycle later. When there is no
    // grant, out keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            if (gnt != 4'b0000) out <= mux_data;
            valid <= |gnt;
        end
    end

endmodule
